// File: rtl/hazard_stall_controller.sv
// Hazard/stall scheduler: forwarding selects, load/branch/jr interlocks,
// data-memory wait FSM with timeout abort, saturating stall-cycle counter.
//
// Ports:
//   i_CLK, i_RST (async, active-low)
//   i_Rs*/i_Rt*/i_WriteReg*          register numbers per stage
//   i_RegWrite*, i_MemtoReg*         write enable / result select (01 = load)
//   i_BranchD, i_JumpRegD            control-flow instructions in D
//   i_MemReqM, i_MemReadyM           data-memory request / completion
//   o_Stall*, o_FlushE, o_FlushW     pipeline register control
//   o_Forward*                       forwarding selects
//   o_MemAbort, o_MemTimeout         timeout pulse / sticky flag
//   o_StallCount                     cycles with o_StallF=1 (saturating)
module hazard_stall_controller #(
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic [1:0]               i_MemtoRegE,
  input  logic [1:0]               i_MemtoRegM,
  input  logic                     i_BranchD,
  input  logic                     i_JumpRegD,
  input  logic                     i_MemReqM,
  input  logic                     i_MemReadyM,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_StallE,
  output logic                     o_StallM,
  output logic                     o_FlushE,
  output logic                     o_FlushW,
  output logic [1:0]               o_ForwardAE,
  output logic [1:0]               o_ForwardBE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic                     o_MemAbort,
  output logic                     o_MemTimeout,
  output logic [COUNT_WIDTH-1:0]   o_StallCount
);

  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WW-1:0]          wcnt_q, wcnt_d;
  logic                   tmo_q, tmo_d;
  logic [COUNT_WIDTH-1:0] scnt_q, scnt_d;

  logic memstall, abort;
  logic lwstall, brstall, jrstall, hz;
  logic ld_e, ld_m;

  // r0 is hard-wired zero, so it never creates a dependency
  function automatic logic hit(
    input logic [RF_ADDR_WIDTH-1:0] a,
    input logic [RF_ADDR_WIDTH-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    o_ForwardAE = 2'b00;
    if (i_RegWriteM && hit(i_RsE, i_WriteRegM))
      o_ForwardAE = 2'b10;
    else if (i_RegWriteW && hit(i_RsE, i_WriteRegW))
      o_ForwardAE = 2'b01;
    o_ForwardBE = 2'b00;
    if (i_RegWriteM && hit(i_RtE, i_WriteRegM))
      o_ForwardBE = 2'b10;
    else if (i_RegWriteW && hit(i_RtE, i_WriteRegW))
      o_ForwardBE = 2'b01;
  end

  assign o_ForwardAD = i_RegWriteM & hit(i_RsD, i_WriteRegM);
  assign o_ForwardBD = i_RegWriteM & hit(i_RtD, i_WriteRegM);

  assign ld_e = (i_MemtoRegE == 2'b01);
  assign ld_m = (i_MemtoRegM == 2'b01);

  assign lwstall = ld_e &
    (hit(i_RtE, i_RsD) | hit(i_RtE, i_RtD));
  assign brstall = i_BranchD & (
    (i_RegWriteE &
      (hit(i_WriteRegE, i_RsD) | hit(i_WriteRegE, i_RtD))) |
    (ld_m &
      (hit(i_WriteRegM, i_RsD) | hit(i_WriteRegM, i_RtD))));
  assign jrstall = i_JumpRegD & (
    (i_RegWriteE & hit(i_WriteRegE, i_RsD)) |
    (ld_m & hit(i_WriteRegM, i_RsD)));
  assign hz = lwstall | brstall | jrstall;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    memstall = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        memstall = i_MemReqM & ~i_MemReadyM;
        if (memstall) begin
          state_d = WAIT;
          wcnt_d  = WW'(1);
        end
      end
      WAIT: begin
        if (i_MemReadyM) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else begin
          memstall = 1'b1;
          if (wcnt_q == LAST) begin
            state_d = ABORT;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ABORT: begin
        // M instruction is released without data; pipeline moves on
        abort   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Memory stall freezes the whole pipe; hz is re-evaluated on release
  always_comb begin
    o_StallF = hz;
    o_StallD = hz;
    o_StallE = 1'b0;
    o_StallM = 1'b0;
    o_FlushE = hz;
    o_FlushW = 1'b0;
    if (memstall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_StallE = 1'b1;
      o_StallM = 1'b1;
      o_FlushE = 1'b0;
      o_FlushW = 1'b1;
    end
  end

  always_comb begin
    tmo_d  = tmo_q | abort;
    scnt_d = scnt_q;
    if (o_StallF && (scnt_q != '1))
      scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      scnt_q  <= scnt_d;
    end
  end

  assign o_MemAbort   = abort;
  assign o_MemTimeout = tmo_q;
  assign o_StallCount = scnt_q;

endmodule
